// File: rtl/data_memory_mc.sv
// Multi-cycle byte-addressed data memory with a req/ack handshake.
// Word accesses are little-endian; misaligned or out-of-range requests are rejected with err_o.
module data_memory_mc #(
  parameter int DEPTH_BYTES = 32,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  logic [7:0]    memory [DEPTH_BYTES];
  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] a_q;
  logic          we_q;
  logic [31:0]   d_q;

  logic          bad;
  logic          go_done;
  logic [AW-1:0] c_a;
  logic          c_we;
  logic [31:0]   c_d;

  assign bad = (addr_i[1:0] != 2'b00) || (addr_i >= 32'(DEPTH_BYTES));

  // The memory access happens on the edge that enters DONE; with LATENCY==1
  // that is the accept edge itself, so the commit uses the live inputs.
  always_comb begin
    go_done = 1'b0;
    c_a     = a_q;
    c_we    = we_q;
    c_d     = d_q;
    if (state == IDLE) begin
      go_done = req_i && !bad && (LATENCY == 1);
      c_a     = addr_i[AW-1:0];
      c_we    = we_i;
      c_d     = data_i;
    end else if (state == WAIT) begin
      go_done = (cnt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      busy_o <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (go_done) begin
        if (c_we) begin
          memory[c_a]           <= c_d[7:0];
          memory[c_a + AW'(1)]  <= c_d[15:8];
          memory[c_a + AW'(2)]  <= c_d[23:16];
          memory[c_a + AW'(3)]  <= c_d[31:24];
        end else begin
          data_o <= {memory[c_a + AW'(3)], memory[c_a + AW'(2)],
                     memory[c_a + AW'(1)], memory[c_a]};
        end
      end
      case (state)
        IDLE: if (req_i) begin
          a_q    <= addr_i[AW-1:0];
          we_q   <= we_i;
          d_q    <= data_i;
          busy_o <= 1'b1;
          if (bad) begin
            state <= ERR;
            ack_o <= 1'b1;
            err_o <= 1'b1;
          end else if (LATENCY == 1) begin
            state <= DONE;
            ack_o <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= CW'(LATENCY - 2);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= DONE;
            ack_o <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE, ERR: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_mc.sv
// Directed bench for data_memory_mc: table of single accesses plus hand-written
// reset-abort, held-request and LATENCY=1 sequences.
module tb_data_memory_mc;
  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [31:0] addr, wdata;
  logic [31:0] dout0, dout1;
  logic        ack0, err0, busy0, ack1, err1, busy1;
  logic        selb = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_memory_mc #(.DEPTH_BYTES(32), .LATENCY(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(dout0), .ack_o(ack0), .err_o(err0), .busy_o(busy0));

  data_memory_mc #(.DEPTH_BYTES(32), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(dout1), .ack_o(ack1), .err_o(err1), .busy_o(busy1));

  logic [31:0] dout_s;
  logic        ack_s, err_s, busy_s;
  assign dout_s = selb ? dout1 : dout0;
  assign ack_s  = selb ? ack1  : ack0;
  assign err_s  = selb ? err1  : err0;
  assign busy_s = selb ? busy1 : busy0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE and wait for its ack; returns in the next IDLE cycle.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] rd,
                        output logic busy_ok);
    lat = -1; e = 1'b0; rd = '0; busy_ok = 1'b1;
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h5a5a_0f0f;
    for (int k = 1; k <= 20; k++) begin
      if (busy_s !== 1'b1) busy_ok = 1'b0;
      if (ack_s === 1'b1) begin
        lat = k; e = err_s; rd = dout_s;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat == -1) begin
      check("ack_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      check("ack_pulse", {31'd0, ack_s}, 32'd0);
      check("busy_idle", {31'd0, busy_s}, 32'd0);
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t        tv [12];
  int          lat;
  logic        e, bok;
  logic [31:0] rd;
  int          nacc;
  logic        prev;
  int          exp_cyc [3];
  logic [31:0] exp_d [3];
  int          nack;

  initial begin
    tv[0]  = '{1'b1, 32'd0,     32'h0000_0005, 4, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 32'd0,     32'hFFFF_FFFF, 4, 1'b0, 32'h5};
    tv[2]  = '{1'b1, 32'd8,     32'hDEAD_BEEF, 4, 1'b0, 32'h5};
    tv[3]  = '{1'b0, 32'd8,     32'hFFFF_FFFF, 4, 1'b0, 32'hDEAD_BEEF};
    tv[4]  = '{1'b0, 32'd2,     32'hFFFF_FFFF, 1, 1'b1, 32'hDEAD_BEEF};
    tv[5]  = '{1'b1, 32'd32,    32'h9999_9999, 1, 1'b1, 32'hDEAD_BEEF};
    tv[6]  = '{1'b1, 32'd4,     32'hA5A5_A5A5, 4, 1'b0, 32'hDEAD_BEEF};
    tv[7]  = '{1'b1, 32'd28,    32'h1122_3344, 4, 1'b0, 32'hDEAD_BEEF};
    tv[8]  = '{1'b0, 32'd28,    32'h0000_0000, 4, 1'b0, 32'h1122_3344};
    tv[9]  = '{1'b1, 32'h100,   32'h7777_7777, 1, 1'b1, 32'h1122_3344};
    tv[10] = '{1'b0, 32'd0,     32'hFFFF_FFFF, 4, 1'b0, 32'h5};
    tv[11] = '{1'b0, 32'd4,     32'h1234_5678, 4, 1'b0, 32'hA5A5_A5A5};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_data",  dout0, 32'd0);
    check("rst_ack",   {31'd0, ack0},  32'd0);
    check("rst_err",   {31'd0, err0},  32'd0);
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_data1", dout1, 32'd0);

    foreach (tv[i]) begin
      access(tv[i].w, tv[i].a, tv[i].d, lat, e, rd, bok);
      check($sformatf("v%0d_lat", i),  32'(lat), 32'(tv[i].lat));
      check($sformatf("v%0d_err", i),  {31'd0, e}, {31'd0, tv[i].e});
      check($sformatf("v%0d_data", i), rd, tv[i].rd);
      check($sformatf("v%0d_busy", i), {31'd0, bok}, 32'd1);
    end
    check("mem8",  {24'd0, dut.memory[8]},  32'hEF);
    check("mem9",  {24'd0, dut.memory[9]},  32'hBE);
    check("mem10", {24'd0, dut.memory[10]}, 32'hAD);
    check("mem11", {24'd0, dut.memory[11]}, 32'hDE);
    check("mem0",  {24'd0, dut.memory[0]},  32'h05);
    check("mem3",  {24'd0, dut.memory[3]},  32'h00);

    // Reset mid-access aborts the write and the ack.
    req = 1'b1; we = 1'b1; addr = 32'd4; wdata = 32'h1234_5678;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_data", dout0, 32'd0);
    nack = 0;
    for (int k = 0; k < 8; k++) begin
      if (ack0 === 1'b1) nack++;
      @(posedge clk); #1;
    end
    check("abort_noack", 32'(nack), 32'd0);
    check("abort_mem4", {24'd0, dut.memory[4]}, 32'hA5);
    check("abort_mem7", {24'd0, dut.memory[7]}, 32'hA5);

    // req_i held high: garbage presented outside IDLE must be ignored.
    exp_cyc = '{4, 9, 14};
    exp_d   = '{32'h5, 32'hA5A5_A5A5, 32'h5};
    we = 1'b0; addr = 32'd0; wdata = 32'd0; req = 1'b1;
    nacc = 0; prev = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 16; k++) begin
      if (ack0 === 1'b1) begin
        if (nacc < 3) begin
          check($sformatf("hold%0d_cyc", nacc),  32'(k), 32'(exp_cyc[nacc]));
          check($sformatf("hold%0d_data", nacc), dout0, exp_d[nacc]);
          check($sformatf("hold%0d_err", nacc),  {31'd0, err0}, 32'd0);
        end else begin
          check("hold_extra_ack", 32'(k), 32'd0);
        end
        nacc++;
        addr = (nacc % 2 == 1) ? 32'd4 : 32'd0; we = 1'b0; wdata = 32'd0;
        if (nacc == 3) req = 1'b0;
        prev = 1'b1;
      end else if (prev) begin
        prev = 1'b0;
      end else begin
        addr = 32'd2; we = 1'b1; wdata = 32'hFFFF_FFFF;
      end
      @(posedge clk); #1;
    end
    req = 1'b0; we = 1'b0; addr = '0;
    check("hold_count", 32'(nacc), 32'd3);
    check("hold_mem0", {24'd0, dut.memory[0]}, 32'h05);
    repeat (3) @(posedge clk); #1;

    // LATENCY=1 instance.
    selb = 1'b1;
    access(1'b1, 32'd12, 32'hCAFE_F00D, lat, e, rd, bok);
    check("l1_wr_lat", 32'(lat), 32'd1);
    check("l1_wr_err", {31'd0, e}, 32'd0);
    repeat (6) @(posedge clk); #1;
    access(1'b0, 32'd12, 32'h0000_0000, lat, e, rd, bok);
    check("l1_rd_lat",  32'(lat), 32'd1);
    check("l1_rd_data", rd, 32'hCAFE_F00D);
    check("l1_rd_err",  {31'd0, e}, 32'd0);
    check("l1_mem12",   {24'd0, dut1.memory[12]}, 32'h0D);
    repeat (6) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
